pcs_sync_rx: RTL and testbench

//  Clause 36 (1000BASE-X) PCS receive synchronization, the stage downstream of TRANSMIT/ENCODE.
//  - Consumes the 10-bit code-group stream produced by ENCODE, one code-group per clock.
//  - Aligns to even/odd code-group position using commas.
//  - Raises code_sync_status and forwards each code-group, with its rx_even tag, to RECEIVE.

---
 rtl/pcs_sync_rx.sv | 184 ++++++++++++++++++
 tb/tb_pcs_sync_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pcs_sync_rx.sv
// 1000BASE-X PCS receive synchronization: comma alignment, code-group validation and sync state machine.
// Optional build macro SYNC_RD_CHECK_EN makes a code-group from the wrong running-disparity column invalid.
module pcs_sync_rx #(
  parameter int GOOD_CGS_MAX = 3,
  parameter int ACQ_COMMAS   = 3
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       signal_detect,
  input  logic [9:0] rx_code_group,
  output logic       code_sync_status,
  output logic       rx_even,
  output logic [9:0] rx_cg_out,
  output logic [3:0] sync_state
);

  localparam int              GW     = (GOOD_CGS_MAX < 2) ? 1 : $clog2(GOOD_CGS_MAX + 1);
  localparam logic [GW-1:0]   GOOD_N = GW'(GOOD_CGS_MAX);
  localparam logic [2:0]      ACQ_N  = 3'(ACQ_COMMAS);

  typedef enum logic [3:0] {
    LOSS_OF_SYNC = 4'd0, COMMA_DETECT = 4'd1, ACQUIRE_SYNC = 4'd2,
    SYNC_ACQ_1   = 4'd3, SYNC_ACQ_2   = 4'd4, SYNC_ACQ_2A  = 4'd5,
    SYNC_ACQ_3   = 4'd6, SYNC_ACQ_3A  = 4'd7, SYNC_ACQ_4   = 4'd8,
    SYNC_ACQ_4A  = 4'd9
  } state_t;

  typedef struct packed {
    logic valid;
    logic is_d;
    logic comma;
    logic rd_out;
  } cg_cls_t;

  // 6b sub-blocks that force the alternate x.7 encoding, and the K23/27/29/30 6b patterns.
  function automatic logic a7_6b(input logic [5:0] s6, input logic rd6);
    if (rd6) a7_6b = (s6 == 6'b110100) || (s6 == 6'b101100) || (s6 == 6'b011100) || (s6 == 6'b001111);
    else     a7_6b = (s6 == 6'b100011) || (s6 == 6'b010011) || (s6 == 6'b001011) || (s6 == 6'b110000);
  endfunction

  function automatic logic kx_6b(input logic [5:0] s6, input logic rd6);
    if (rd6) kx_6b = (s6 == 6'b111010) || (s6 == 6'b110110) || (s6 == 6'b101110) || (s6 == 6'b011110);
    else     kx_6b = (s6 == 6'b000101) || (s6 == 6'b001001) || (s6 == 6'b010001) || (s6 == 6'b100001);
  endfunction

  function automatic logic rd_mid(input logic [5:0] s6, input logic rd);
    int n6;
    n6 = $countones(s6);
    rd_mid = (n6 == 4) ? 1'b1 : (n6 == 2) ? 1'b0 : rd;
  endfunction

  // Legal in the column selected by rd (rd = 1 means positive running disparity).
  function automatic logic cg_legal(input logic [9:0] cg, input logic rd);
    logic [5:0] s6;
    logic [3:0] s4;
    logic       rd6, ok6, ok4, a7, kx;
    int         n6, n4;
    s6  = cg[9:4];
    s4  = cg[3:0];
    n6  = $countones(s6);
    n4  = $countones(s4);
    ok6 = (n6 == 3 && !(s6 == 6'b111000 && rd) && !(s6 == 6'b000111 && !rd)) ||
          (n6 == 4 && !rd && s6 != 6'b111100) ||
          (n6 == 2 &&  rd && s6 != 6'b000011);
    rd6 = rd_mid(s6, rd);
    ok4 = (n4 == 2 && !(s4 == 4'b1100 && rd6) && !(s4 == 4'b0011 && !rd6)) ||
          (n4 == 3 && !rd6) || (n4 == 1 && rd6);
    a7  = a7_6b(s6, rd6);
    kx  = kx_6b(s6, rd6);
    if (rd6) begin
      if (s4 == 4'b0001 && a7)          ok4 = 1'b0;
      if (s4 == 4'b1000 && !(a7 || kx)) ok4 = 1'b0;
    end else begin
      if (s4 == 4'b1110 && a7)          ok4 = 1'b0;
      if (s4 == 4'b0111 && !(a7 || kx)) ok4 = 1'b0;
    end
    cg_legal = ok6 && ok4;
  endfunction

  function automatic logic cg_is_k(input logic [9:0] cg);
    logic [5:0] s6;
    logic [3:0] s4;
    s6 = cg[9:4];
    s4 = cg[3:0];
    cg_is_k = (s6 == 6'b001111) || (s6 == 6'b110000) ||
              (s4 == 4'b1000 && kx_6b(s6, 1'b1)) ||
              (s4 == 4'b0111 && kx_6b(s6, 1'b0));
  endfunction

  state_t        state, nxt;
  logic          rd;
  logic [2:0]    comma_cnt;
  logic [GW-1:0] good_cgs, gc_nxt;
  logic          cnt_inc, cgbad, legal_any;
  cg_cls_t       cls;

`ifdef SYNC_RD_CHECK_EN
  assign legal_any = cg_legal(rx_code_group, rd);
`else
  assign legal_any = cg_legal(rx_code_group, rd) | cg_legal(rx_code_group, ~rd);
`endif

  always_comb begin
    cls        = '0;
    cls.valid  = legal_any;
    cls.is_d   = legal_any & ~cg_is_k(rx_code_group);
    cls.comma  = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
    cls.rd_out = rd;
    if (legal_any) begin
      case ($countones(rx_code_group[3:0]))
        3:       cls.rd_out = 1'b1;
        1:       cls.rd_out = 1'b0;
        default: cls.rd_out = rd_mid(rx_code_group[9:4], rd);
      endcase
    end
  end

  assign cgbad = ~cls.valid | (cls.comma & rx_even);

  always_comb begin
    nxt     = state;
    gc_nxt  = '0;
    cnt_inc = 1'b0;
    if (!signal_detect) nxt = LOSS_OF_SYNC;
    else begin
      case (state)
        LOSS_OF_SYNC: if (cls.comma) begin nxt = COMMA_DETECT; cnt_inc = 1'b1; end
        COMMA_DETECT: begin
          if (cls.is_d && comma_cnt == ACQ_N) nxt = SYNC_ACQ_1;
          else if (cls.is_d)                  nxt = ACQUIRE_SYNC;
          else                                nxt = LOSS_OF_SYNC;
        end
        ACQUIRE_SYNC: begin
          if (cgbad) nxt = LOSS_OF_SYNC;
          else if (cls.comma && !rx_even) begin nxt = COMMA_DETECT; cnt_inc = 1'b1; end
        end
        SYNC_ACQ_1: if (cgbad) nxt = SYNC_ACQ_2;
        SYNC_ACQ_2: begin nxt = cgbad ? SYNC_ACQ_3   : SYNC_ACQ_2A; gc_nxt = cgbad ? '0 : GW'(1); end
        SYNC_ACQ_3: begin nxt = cgbad ? SYNC_ACQ_4   : SYNC_ACQ_3A; gc_nxt = cgbad ? '0 : GW'(1); end
        SYNC_ACQ_4: begin nxt = cgbad ? LOSS_OF_SYNC : SYNC_ACQ_4A; gc_nxt = cgbad ? '0 : GW'(1); end
        SYNC_ACQ_2A: begin
          if (cgbad)                   nxt = SYNC_ACQ_3;
          else if (good_cgs == GOOD_N) nxt = SYNC_ACQ_1;
          else                         gc_nxt = good_cgs + 1'b1;
        end
        SYNC_ACQ_3A: begin
          if (cgbad)                   nxt = SYNC_ACQ_4;
          else if (good_cgs == GOOD_N) nxt = SYNC_ACQ_2;
          else                         gc_nxt = good_cgs + 1'b1;
        end
        SYNC_ACQ_4A: begin
          if (cgbad)                   nxt = LOSS_OF_SYNC;
          else if (good_cgs == GOOD_N) nxt = SYNC_ACQ_3;
          else                         gc_nxt = good_cgs + 1'b1;
        end
        default: nxt = LOSS_OF_SYNC;
      endcase
    end
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state     <= LOSS_OF_SYNC;
      rd        <= 1'b0;
      comma_cnt <= '0;
      good_cgs  <= '0;
      rx_even   <= 1'b0;
      rx_cg_out <= '0;
    end else begin
      state     <= nxt;
      rd        <= cls.rd_out;
      good_cgs  <= gc_nxt;
      // A comma that (re)enters COMMA_DETECT defines the even position.
      rx_even   <= (nxt == COMMA_DETECT) ? 1'b1 : ~rx_even;
      rx_cg_out <= rx_code_group;
      if (nxt == LOSS_OF_SYNC)          comma_cnt <= '0;
      else if (cnt_inc && comma_cnt != 3'd7) comma_cnt <= comma_cnt + 3'd1;
    end
  end

  assign sync_state       = state;
  assign code_sync_status = (state >= SYNC_ACQ_1);

endmodule

// File: tb/tb_pcs_sync_rx.sv
// Directed bench for pcs_sync_rx: table-driven acquisition plus hand-written error, loss and reset sequences.
module tb_pcs_sync_rx;

  localparam logic [9:0] K_N = 10'b0011111010;  // K28.5 from RD-
  localparam logic [9:0] K_P = 10'b1100000101;  // K28.5 from RD+
  localparam logic [9:0] D_P = 10'b1001000101;  // D16.2 from RD+
  localparam logic [9:0] D_N = 10'b0110110101;  // D16.2 from RD-
  localparam logic [9:0] ERR = 10'h000;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset;
  logic       signal_detect;
  logic [9:0] rx_code_group;
  logic       code_sync_status, rx_even;
  logic [9:0] rx_cg_out;
  logic [3:0] sync_state;

  int   errors = 0;
  int   checks = 0;
  logic tb_rd  = 1'b0;

  typedef struct packed {
    logic       sd;
    logic [9:0] cg;
    logic [3:0] st;
    logic       status;
    logic       even;
  } vec_t;

  vec_t tbl [10];

  pcs_sync_rx dut (
    .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .signal_detect(signal_detect),
    .rx_code_group(rx_code_group), .code_sync_status(code_sync_status), .rx_even(rx_even),
    .rx_cg_out(rx_cg_out), .sync_state(sync_state)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  task automatic check(input string name, input logic [3:0] es, input logic est,
                       input logic ee, input logic [9:0] ecg);
    checks++;
    if ({sync_state, code_sync_status, rx_even, rx_cg_out} !== {es, est, ee, ecg}) begin
      errors++;
      $display("FAIL %s: got state=%0d status=%0b even=%0b cg_out=%h, want state=%0d status=%0b even=%0b cg_out=%h",
               name, sync_state, code_sync_status, rx_even, rx_cg_out, es, est, ee, ecg);
    end
  endtask

  task automatic step(input string name, input logic sd, input logic [9:0] cg,
                      input logic [3:0] es, input logic est, input logic ee);
    signal_detect = sd;
    rx_code_group = cg;
    @(posedge GTX_CLK);
    #1;
    check(name, es, est, ee, cg);
  endtask

  // K28.5 / D16.2 from the column matching the bench's running disparity; both flip it.
  task automatic send_k(input string name, input logic [3:0] es, input logic est, input logic ee);
    step(name, 1'b1, tb_rd ? K_P : K_N, es, est, ee);
    tb_rd = ~tb_rd;
  endtask

  task automatic send_d(input string name, input logic [3:0] es, input logic est, input logic ee);
    step(name, 1'b1, tb_rd ? D_P : D_N, es, est, ee);
    tb_rd = ~tb_rd;
  endtask

  task automatic resync(input string name);
    send_k({name, "_k1"}, 4'd1, 1'b0, 1'b1);
    send_d({name, "_d1"}, 4'd2, 1'b0, 1'b0);
    send_k({name, "_k2"}, 4'd1, 1'b0, 1'b1);
    send_d({name, "_d2"}, 4'd2, 1'b0, 1'b0);
    send_k({name, "_k3"}, 4'd1, 1'b0, 1'b1);
    send_d({name, "_d3"}, 4'd3, 1'b1, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, K_N, 4'd1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, D_P, 4'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, K_N, 4'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, D_P, 4'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b1, K_N, 4'd1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, D_P, 4'd3, 1'b1, 1'b0};
    tbl[6] = '{1'b1, K_N, 4'd3, 1'b1, 1'b1};
    tbl[7] = '{1'b1, D_P, 4'd3, 1'b1, 1'b0};
    tbl[8] = '{1'b1, K_N, 4'd3, 1'b1, 1'b1};
    tbl[9] = '{1'b1, D_P, 4'd3, 1'b1, 1'b0};

    mr_main_reset = 1'b0;
    signal_detect = 1'b1;
    rx_code_group = 10'h3FF;
    #2;
    check("reset_state", 4'd0, 1'b0, 1'b0, 10'h000);
    @(posedge GTX_CLK);
    #1;
    check("reset_held", 4'd0, 1'b0, 1'b0, 10'h000);
    mr_main_reset = 1'b1;

    for (int i = 0; i < 10; i++)
      step($sformatf("acq_%0d", i), tbl[i].sd, tbl[i].cg, tbl[i].st, tbl[i].status, tbl[i].even);
    tb_rd = 1'b0;

    // Single error in an even slot, then recovery through SA_2A after four good code-groups.
    step("t3_err", 1'b1, ERR, 4'd4, 1'b1, 1'b1);
    send_d("t3_g1", 4'd5, 1'b1, 1'b0);
    send_k("t3_g2", 4'd5, 1'b1, 1'b1);
    send_d("t3_g3", 4'd5, 1'b1, 1'b0);
    send_k("t3_g4", 4'd3, 1'b1, 1'b1);

    // Four errors each separated by one good code-group.
    send_d("t4_g0", 4'd3, 1'b1, 1'b0);
    step("t4_e1", 1'b1, ERR, 4'd4, 1'b1, 1'b1);
    send_d("t4_g1", 4'd5, 1'b1, 1'b0);
    step("t4_e2", 1'b1, ERR, 4'd6, 1'b1, 1'b1);
    send_d("t4_g2", 4'd7, 1'b1, 1'b0);
    step("t4_e3", 1'b1, ERR, 4'd8, 1'b1, 1'b1);
    send_d("t4_g3", 4'd9, 1'b1, 1'b0);
    step("t4_e4", 1'b1, ERR, 4'd0, 1'b0, 1'b1);

    // Comma in an odd slot while acquiring.
    send_k("t5_k", 4'd1, 1'b0, 1'b1);
    send_d("t5_d1", 4'd2, 1'b0, 1'b0);
    send_d("t5_d2", 4'd2, 1'b0, 1'b1);
    send_k("t5_odd_k", 4'd0, 1'b0, 1'b0);

    resync("t6a_sync");
    step("t6a_nosig", 1'b0, ERR, 4'd0, 1'b0, 1'b1);
    resync("t6b_sync");

    // Wrong-disparity comma while the receiver's RD is negative.
`ifdef SYNC_RD_CHECK_EN
    step("t6b_wrong_rd", 1'b1, K_P, 4'd4, 1'b1, 1'b1);
`else
    step("t6b_wrong_rd", 1'b1, K_P, 4'd3, 1'b1, 1'b1);
`endif

    // Asynchronous reset mid-stream, then comma count must restart from zero.
    rx_code_group = D_P;
    #2;
    mr_main_reset = 1'b0;
    #1;
    check("t1_async_reset", 4'd0, 1'b0, 1'b0, 10'h000);
    @(posedge GTX_CLK);
    #1;
    mr_main_reset = 1'b1;
    tb_rd = 1'b0;
    send_k("t1_post_k", 4'd1, 1'b0, 1'b1);
    send_d("t1_post_d", 4'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
